// File: rtl/keypad_digit_entry.sv
// 4x4 matrix keypad scanner with row synchroniser, tick-based debounce and key
// decode driving the digit/digitEn/instrEn inputs of the VGA digit display.
module keypad_digit_entry #(
    parameter logic [15:0] SCAN_DIV = 16'd40000,
    parameter logic [3:0]  DEBOUNCE = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic       instrEn,
    output logic       keyPulse
);
    localparam logic [1:0] SCAN    = 2'd0;
    localparam logic [1:0] PRESS   = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [3:0]  rsync, rs;
    logic [15:0] div;
    logic        tick;
    logic [1:0]  colIdx, state, candRow, rowIdx;
    logic [3:0]  cnt;
    logic        oneLow, allHigh, accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsync <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            rsync <= rows;
            rs    <= rsync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 16'd1;
    end

    assign tick    = (div == SCAN_DIV - 16'd1);
    assign cols    = ~(4'b0001 << colIdx);
    assign allHigh = (rs == 4'b1111);

    always_comb begin
        oneLow = 1'b1;
        rowIdx = 2'd0;
        case (rs)
            4'b1110: rowIdx = 2'd0;
            4'b1101: rowIdx = 2'd1;
            4'b1011: rowIdx = 2'd2;
            4'b0111: rowIdx = 2'd3;
            default: oneLow = 1'b0;
        endcase
    end

    // colIdx is frozen while debouncing, so the live rowIdx/colIdx name the candidate key
    assign accept = tick && oneLow &&
                    (((state == SCAN) && (DEBOUNCE == 4'd1)) ||
                     ((state == PRESS) && (rowIdx == candRow) && (cnt + 4'd1 == DEBOUNCE)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            colIdx  <= 2'd0;
            candRow <= 2'd0;
            cnt     <= 4'd0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (oneLow) begin
                        candRow <= rowIdx;
                        cnt     <= 4'd1;
                        state   <= (DEBOUNCE > 4'd1) ? PRESS : HELD;
                    end else begin
                        colIdx <= colIdx + 2'd1;
                    end
                end
                PRESS: begin
                    if (oneLow && rowIdx == candRow) begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == DEBOUNCE) state <= HELD;
                    end else begin
                        cnt   <= 4'd0;
                        state <= SCAN;
                    end
                end
                HELD: begin
                    if (allHigh) begin
                        cnt   <= 4'd1;
                        state <= (DEBOUNCE == 4'd1) ? SCAN : RELEASE;
                    end
                end
                default: begin
                    if (allHigh) begin
                        if (cnt + 4'd1 == DEBOUNCE) begin
                            cnt   <= 4'd0;
                            state <= SCAN;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        cnt   <= 4'd0;
                        state <= HELD;
                    end
                end
            endcase
        end
    end

    // Column 3 holds the letter keys, which are consumed silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit    <= 4'd0;
            digitEn  <= 1'b0;
            instrEn  <= 1'b1;
            keyPulse <= 1'b0;
        end else begin
            keyPulse <= 1'b0;
            if (accept && colIdx != 2'd3) begin
                keyPulse <= 1'b1;
                if (rowIdx != 2'd3) begin
                    digit   <= {2'b00, rowIdx} * 4'd3 + {2'b00, colIdx} + 4'd1;
                    digitEn <= 1'b1;
                    instrEn <= 1'b0;
                end else begin
                    case (colIdx)
                        2'd0: instrEn <= 1'b1;
                        2'd1: begin
                            digit   <= 4'd0;
                            digitEn <= 1'b1;
                            instrEn <= 1'b0;
                        end
                        default: begin
                            digitEn <= 1'b0;
                            instrEn <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: a physical keypad matrix model drives rows from
// cols; expected outputs come from a key-event model over the key legend.
module tb_keypad_digit_entry;
    localparam logic [15:0] SD = 16'd4;
    localparam logic [3:0]  DB = 4'd3;

    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] rows, cols, digit;
    logic       digitEn, instrEn, keyPulse;
    logic [3:0][3:0] pressed = '0;  // [row][col]

    int tests = 0, fails = 0, pulses = 0;
    logic [3:0] m_digit;
    logic       m_den, m_ien;
    string      km = "123A456B789C*0#D";

    keypad_digit_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .digit(digit), .digitEn(digitEn), .instrEn(instrEn), .keyPulse(keyPulse));

    always #5 clk = ~clk;

    // A closed switch pulls its row low only while its column is driven low
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) if (keyPulse) pulses <= pulses + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] want, output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (cols === want) begin ok = 1; break; end
        end
    endtask

    task automatic wait_col_leave(input logic [3:0] from, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cols !== from) begin ok = 1; break; end
        end
    endtask

    task automatic model_reset();
        m_digit = 4'd0; m_den = 1'b0; m_ien = 1'b1;
    endtask

    // Returns 1 when the key should produce a keyPulse
    function automatic int model_key(input int r, input int c);
        byte ch;
        ch = km[r*4 + c];
        if (ch >= 8'h30 && ch <= 8'h39) begin
            m_digit = 4'(ch - 8'h30); m_den = 1'b1; m_ien = 1'b0; return 1;
        end
        if (ch == "*") begin m_ien = 1'b1; return 1; end
        if (ch == "#") begin m_den = 1'b0; m_ien = 1'b0; return 1; end
        return 0;
    endfunction

    task automatic press_key(input int r, input int c, input int hold, input int rel);
        pressed[r][c] = 1'b1;
        step(hold);
        pressed = '0;
        step(rel);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        pressed = '0;
        reset = 1'b0;
        step(2);
        model_reset();
        tests++;
        if ({digit, digitEn, instrEn, keyPulse, cols} !== {m_digit, m_den, m_ien, 1'b0, 4'b1110}) begin
            fails++;
            $display("FAIL reset_values: got %h want %h", {digit, digitEn, instrEn, keyPulse, cols},
                     {m_digit, m_den, m_ien, 1'b0, 4'b1110});
        end
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            e = ~(4'b0001 << ((k / 4) % 4));
            tests++;
            if (cols !== e) begin
                fails++;
                $display("FAIL idle_cols edge %0d: got %b want %b", k, cols, e);
            end
        end
    endtask

    task automatic test_press5();
        int p0;
        bit ok;
        p0 = pulses;
        pressed[1][1] = 1'b1;
        wait_col(4'b1101, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL press5_col: got %b want 1101", cols); end
        step(11);
        tests++;
        if (digitEn !== 1'b0 || keyPulse !== 1'b0) begin
            fails++;
            $display("FAIL press5_early: got den=%b pulse=%b want 0 0", digitEn, keyPulse);
        end
        step(1);
        void'(model_key(1, 1));
        tests++;
        if ({digit, digitEn, instrEn, keyPulse} !== {m_digit, m_den, m_ien, 1'b1}) begin
            fails++;
            $display("FAIL press5_accept: got %h want %h", {digit, digitEn, instrEn, keyPulse},
                     {m_digit, m_den, m_ien, 1'b1});
        end
        step(1);
        tests++;
        if (keyPulse !== 1'b0) begin fails++; $display("FAIL press5_pulse_width: got %b want 0", keyPulse); end
        pressed = '0;
        wait_col_leave(4'b1101, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL press5_resume_scan: got %b want moving", cols); end
        step(10);
        tests++;
        if (pulses - p0 !== 1) begin fails++; $display("FAIL press5_pulses: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_bounce();
        int p0;
        bit ok;
        p0 = pulses;
        wait_col(4'b1110, ok);
        pressed[0][0] = 1'b1;
        step(8);
        pressed = '0;
        wait_col_leave(4'b1110, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bounce_resume_scan: got %b want moving", cols); end
        step(20);
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses != p0) begin
            fails++;
            $display("FAIL bounce_no_accept: got %h pulses %0d want %h pulses %0d",
                     {digit, digitEn, instrEn}, pulses - p0, {m_digit, m_den, m_ien}, 0);
        end
    endtask

    task automatic test_star_hash();
        int p0;
        press_key(2, 0, 40, 30);
        void'(model_key(2, 0));
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien}) begin
            fails++; $display("FAIL key7: got %h want %h", {digit, digitEn, instrEn}, {m_digit, m_den, m_ien});
        end
        p0 = pulses;
        press_key(3, 0, 40, 30);
        void'(model_key(3, 0));
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien}) begin
            fails++; $display("FAIL key_star: got %h want %h", {digit, digitEn, instrEn}, {m_digit, m_den, m_ien});
        end
        press_key(3, 2, 40, 30);
        void'(model_key(3, 2));
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien}) begin
            fails++; $display("FAIL key_hash: got %h want %h", {digit, digitEn, instrEn}, {m_digit, m_den, m_ien});
        end
        tests++;
        if (pulses - p0 !== 2) begin fails++; $display("FAIL star_hash_pulses: got %0d want 2", pulses - p0); end
    endtask

    task automatic test_letter_multi();
        int p0;
        p0 = pulses;
        pressed[0][3] = 1'b1;
        step(40);
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses != p0) begin
            fails++; $display("FAIL key_A: got %h pulses %0d want %h pulses 0",
                              {digit, digitEn, instrEn}, pulses - p0, {m_digit, m_den, m_ien});
        end
        pressed[2][2] = 1'b1;
        step(40);
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses != p0) begin
            fails++; $display("FAIL held_A_blocks_9: got %h pulses %0d want %h pulses 0",
                              {digit, digitEn, instrEn}, pulses - p0, {m_digit, m_den, m_ien});
        end
        pressed[0][3] = 1'b0;
        step(60);
        p0 += model_key(2, 2);
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses != p0) begin
            fails++; $display("FAIL key9_after_A: got %h pulses %0d want %h",
                              {digit, digitEn, instrEn}, pulses, {m_digit, m_den, m_ien});
        end
        pressed = '0;
        step(30);
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        step(60);
        tests++;
        if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses != p0) begin
            fails++; $display("FAIL multi_row: got %h pulses %0d want %h",
                              {digit, digitEn, instrEn}, pulses, {m_digit, m_den, m_ien});
        end
        pressed = '0;
        step(30);
    endtask

    task automatic test_reset_mid();
        bit ok;
        pressed[2][1] = 1'b1;
        wait_col(4'b1101, ok);
        step(5);
        #($urandom_range(1, 7));
        reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({digit, digitEn, instrEn, keyPulse, cols} !== {m_digit, m_den, m_ien, 1'b0, 4'b1110}) begin
            fails++; $display("FAIL async_reset: got %h want %h", {digit, digitEn, instrEn, keyPulse, cols},
                              {m_digit, m_den, m_ien, 1'b0, 4'b1110});
        end
        @(posedge clk);
        #($urandom_range(1, 4));
        reset = 1'b1;
        wait_col(4'b1101, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL reset_mid_col: got %b want 1101", cols); end
        step(11);
        tests++;
        if (digitEn !== 1'b0) begin fails++; $display("FAIL reset_mid_early: got %b want 0", digitEn); end
        step(1);
        void'(model_key(2, 1));
        tests++;
        if ({digit, digitEn, instrEn, keyPulse} !== {m_digit, m_den, m_ien, 1'b1}) begin
            fails++; $display("FAIL reset_mid_accept: got %h want %h", {digit, digitEn, instrEn, keyPulse},
                              {m_digit, m_den, m_ien, 1'b1});
        end
        pressed = '0;
        step(30);
    endtask

    task automatic test_random();
        int r, c, p0, exp_p;
        for (int i = 0; i < 12; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            p0 = pulses;
            exp_p = 0;
            if ($urandom_range(0, 3) == 0) begin
                press_key(r, c, $urandom_range(1, 6), 20);
            end else begin
                press_key(r, c, $urandom_range(40, 50), $urandom_range(30, 40));
                exp_p = model_key(r, c);
            end
            tests++;
            if ({digit, digitEn, instrEn} !== {m_digit, m_den, m_ien} || pulses - p0 != exp_p) begin
                fails++;
                $display("FAIL random %0d key %s: got %h pulses %0d want %h pulses %0d", i,
                         string'(km[r*4+c]), {digit, digitEn, instrEn}, pulses - p0,
                         {m_digit, m_den, m_ien}, exp_p);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_press5();
        test_bounce();
        test_star_hash();
        test_letter_multi();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
